// File: rtl/mdc_output_reorder.sv
// mdc_output_reorder: collects bit-reversed lane pairs from the radix-2 MDC
// FFT core into a two-bank ping-pong store and replays each N-point frame as
// one natural-order complex stream with bin index and end-of-frame marker.
//
// Output handshake: a word transfers on a rising edge where io_out_valid and
// io_out_ready are both high. While io_out_valid is high and io_out_ready is
// low, io_out_real/imag/index/last hold their values. io_out_valid never drops
// without a transfer, except under reset.
module mdc_output_reorder #(
    parameter int N = 512,
    parameter int W = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] io_in1_real,
    input  logic [W-1:0] io_in1_imag,
    input  logic [W-1:0] io_in2_real,
    input  logic [W-1:0] io_in2_imag,
    input  logic         io_in_valid,
    output logic [W-1:0] io_out_real,
    output logic [W-1:0] io_out_imag,
    output logic [L-1:0] io_out_index,
    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic         io_out_last,
    output logic         io_overflow
);

    localparam int H = N / 2;
    localparam logic [L-1:0] LAST_IDX = L'(N - 1);

    typedef enum logic [1:0] {
        B_EMPTY    = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    bank_t        bank_st [2];
    rd_state_t    rd_state;
    logic         wptr;
    logic         rptr;
    logic         wr_active;
    logic         overflow;
    logic [L-2:0] kin;
    logic [L-2:0] wr_off;
    logic [L-1:0] raddr;
    logic [L-1:0] out_index;
    logic         out_valid;
    logic [2*W-1:0] out_data;
    logic [2*W-1:0] rd_word;
    logic         wr_en;
    logic         kin_last;
    logic         rd_accept;

    // Lower half (lane1) and upper half (lane2) of each bank, indexed {bank, offset}.
    logic [2*W-1:0] mem_lo [N];
    logic [2*W-1:0] mem_hi [N];

    // Lane1 address is bitrev_L(2k); its top bit is always 0 and the remaining
    // bits are k reversed over L-1 bits. Lane2 sits N/2 above at the same offset.
    always_comb begin
        wr_off = '0;
        for (int i = 0; i < L - 1; i++) begin
            wr_off[i] = kin[L-2-i];
        end
    end

    // A frame writes only if its bank was EMPTY when pair 0 arrived.
    assign wr_en     = io_in_valid && ((kin == '0) ? (bank_st[wptr] == B_EMPTY) : wr_active);
    assign kin_last  = &kin;
    assign rd_accept = out_valid && io_out_ready;

    // Select the read word from the half that holds the natural-order address.
    always_comb begin
        rd_word = mem_lo[{rptr, raddr[L-2:0]}];
        if (raddr[L-1]) begin
            rd_word = mem_hi[{rptr, raddr[L-2:0]}];
        end
    end

    // Both lanes of a pair are written in the same cycle.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_lo[{wptr, wr_off}] <= {io_in1_real, io_in1_imag};
            mem_hi[{wptr, wr_off}] <= {io_in2_real, io_in2_imag};
        end
    end

    // Writer bookkeeping, bank states and reader FSM. Bank states are updated
    // from their pre-edge values, so a frame start that coincides with the
    // reader freeing its target bank is still treated as a drop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
            wptr       <= 1'b0;
            rptr       <= 1'b0;
            kin        <= '0;
            wr_active  <= 1'b0;
            overflow   <= 1'b0;
            rd_state   <= RD_IDLE;
            raddr      <= '0;
            out_index  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            overflow <= 1'b0;

            if (io_in_valid) begin
                kin <= kin + 1'b1;
                if (kin == '0) begin
                    if (bank_st[wptr] == B_EMPTY) begin
                        bank_st[wptr] <= B_FILLING;
                        wr_active     <= 1'b1;
                    end else begin
                        overflow  <= 1'b1;
                        wr_active <= 1'b0;
                    end
                end
                // A dropped frame leaves the writer on the same bank so the
                // reader still sees frames in arrival order.
                if (kin_last && wr_active) begin
                    bank_st[wptr] <= B_FULL;
                    wptr          <= ~wptr;
                    wr_active     <= 1'b0;
                end
            end

            case (rd_state)
                RD_IDLE: begin
                    if (bank_st[rptr] == B_FULL) begin
                        bank_st[rptr] <= B_DRAINING;
                        rd_state      <= RD_PRIME;
                    end
                end
                RD_PRIME: begin
                    // raddr is 0 here: it wraps to 0 after address N-1 is read.
                    out_data  <= rd_word;
                    out_valid <= 1'b1;
                    out_index <= '0;
                    raddr     <= raddr + 1'b1;
                    rd_state  <= RD_STREAM;
                end
                RD_STREAM: begin
                    if (rd_accept) begin
                        if (out_index == LAST_IDX) begin
                            out_valid     <= 1'b0;
                            bank_st[rptr] <= B_EMPTY;
                            rptr          <= ~rptr;
                            rd_state      <= RD_IDLE;
                        end else begin
                            out_data  <= rd_word;
                            out_index <= out_index + 1'b1;
                            raddr     <= raddr + 1'b1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign io_out_real  = out_data[2*W-1:W];
    assign io_out_imag  = out_data[W-1:0];
    assign io_out_index = out_index;
    assign io_out_valid = out_valid;
    assign io_out_last  = out_valid && (out_index == LAST_IDX);
    assign io_overflow  = overflow;

endmodule

// File: tb/tb_mdc_output_reorder.sv
// Bench for mdc_output_reorder: frames of bit-reversed pairs are driven in,
// the natural-order words each accepted frame should produce are queued, and
// every output transfer is popped and compared.
module tb_mdc_output_reorder;

    localparam int N  = 512;
    localparam int W  = 32;
    localparam int L  = 9;
    localparam int H  = N / 2;
    localparam int PW = 2 * W + L + 2;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] io_in1_real = '0;
    logic [W-1:0] io_in1_imag = '0;
    logic [W-1:0] io_in2_real = '0;
    logic [W-1:0] io_in2_imag = '0;
    logic         io_in_valid = 1'b0;
    logic [W-1:0] io_out_real;
    logic [W-1:0] io_out_imag;
    logic [L-1:0] io_out_index;
    logic         io_out_valid;
    logic         io_out_ready = 1'b0;
    logic         io_out_last;
    logic         io_overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 1;     // 0: ready low, 1: ready high, 2: random 50%
    int ovf_cnt  = 0;
    int ovf_cyc  = -1;
    int valid_seen = 0;
    int pair0_cyc = 0;
    int last_pair_cyc = 0;
    bit stalled = 1'b0;
    logic [PW-1:0] hold_word;
    logic [PW-1:0] exp_q[$];

    mdc_output_reorder #(.N(N), .W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in1_real  (io_in1_real),
        .io_in1_imag  (io_in1_imag),
        .io_in2_real  (io_in2_real),
        .io_in2_imag  (io_in2_imag),
        .io_in_valid  (io_in_valid),
        .io_out_real  (io_out_real),
        .io_out_imag  (io_out_imag),
        .io_out_index (io_out_index),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_last  (io_out_last),
        .io_overflow  (io_overflow)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d limit reached", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < L; i++) begin
            if (v[i]) r = r | (1 << (L - 1 - i));
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] exp_word(input int base, input int a);
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [L-1:0] ix;
        logic         lst;
        re  = W'(base + a);
        im  = -re;
        ix  = L'(a);
        lst = (a == N - 1);
        return {1'b1, re, im, ix, lst};
    endfunction

    function automatic logic [PW-1:0] obs_word();
        return {io_out_valid, io_out_real, io_out_imag, io_out_index, io_out_last};
    endfunction

    // Scoreboard: pick ready for the coming edge, then compare any word that
    // edge will accept; also watch stall stability and overflow pulses.
    always @(negedge clock) begin
        case (ready_mode)
            0:       io_out_ready = 1'b0;
            1:       io_out_ready = 1'b1;
            default: io_out_ready = 1'($urandom_range(0, 1));
        endcase
        if (reset) begin
            if (stalled) check("stall_hold", obs_word(), hold_word);
            if (io_out_valid) valid_seen++;
            if (io_out_valid && io_out_ready) begin
                check("q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("out_word", obs_word(), exp_q.pop_front());
            end
            stalled   = io_out_valid && !io_out_ready;
            hold_word = obs_word();
            if (io_overflow) begin
                ovf_cnt++;
                ovf_cyc = cyc;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    // Drive npairs pairs of a frame whose bin a carries base+a; gap idle
    // cycles follow each pair. Leaves io_in_valid as last driven.
    task automatic drive_frame(input int base, input int gap, input bit accept, input int npairs);
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        if (accept) begin
            for (int a = 0; a < N; a++) exp_q.push_back(exp_word(base, a));
        end
        for (int k = 0; k < npairs; k++) begin
            @(negedge clock);
            r1 = W'(base + bitrev(2 * k));
            r2 = W'(base + bitrev(2 * k + 1));
            io_in_valid = 1'b1;
            io_in1_real = r1;
            io_in1_imag = -r1;
            io_in2_real = r2;
            io_in2_imag = -r2;
            if (k == 0) pair0_cyc = cyc;
            last_pair_cyc = cyc;
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                io_in_valid = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            io_in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clock);
            io_in_valid = 1'b0;
            t++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, io_out_valid, 0);
        check({tag, "_last"},  io_out_last, 0);
        check({tag, "_ovf"},   io_overflow, 0);
        check({tag, "_real"},  io_out_real, 0);
        check({tag, "_imag"},  io_out_imag, 0);
        check({tag, "_index"}, io_out_index, 0);
    endtask

    // Stimulus sequence
    initial begin
        int t;

        // Power-on reset
        repeat (3) @(negedge clock);
        check_reset_outputs("rst_init");
        reset = 1'b1;

        // Partial frame, then reset mid-stream for 3 cycles; it must be discarded
        drive_frame(9000, 0, 1'b0, 100);
        @(negedge clock);
        #1 reset = 1'b0;
        io_in_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst_mid");
        reset = 1'b1;
        valid_seen = 0;
        idle(20);
        check("rst_no_valid", valid_seen, 0);

        // Ordering and first-word latency
        ready_mode = 1;
        drive_frame(0, 0, 1'b1, H);
        t = 0;
        do begin
            @(negedge clock);
            io_in_valid = 1'b0;
            t++;
        end while (!io_out_valid && t < 50);
        check("first_valid_lat", cyc - last_pair_cyc, 3);
        wait_drain("order_drain", 2000);

        // Random backpressure
        ready_mode = 2;
        drive_frame(0, 0, 1'b1, H);
        idle(1);
        wait_drain("bp_drain", 4000);
        ready_mode = 1;
        idle(4);

        // Ping-pong at 50% input duty
        ovf_cnt = 0;
        drive_frame(N, 1, 1'b1, H);
        drive_frame(2 * N, 1, 1'b1, H);
        wait_drain("pp_drain", 3000);
        check("pp_ovf", ovf_cnt, 0);

        // Overflow: three back-to-back frames with ready low
        ready_mode = 0;
        idle(2);
        ovf_cnt = 0;
        drive_frame(2000, 0, 1'b1, H);
        drive_frame(3000, 0, 1'b1, H);
        drive_frame(4000, 0, 1'b0, H);
        idle(2);
        check("ovf_count", ovf_cnt, 1);
        check("ovf_when", ovf_cyc, pair0_cyc + 1);
        ready_mode = 1;
        wait_drain("ovf_drain", 3000);
        idle(10);
        drive_frame(5000, 0, 1'b1, H);
        idle(1);
        wait_drain("ovf_f4_drain", 2000);
        check("ovf_count_final", ovf_cnt, 1);

        // Reset mid-drain at output index 200
        drive_frame(6000, 0, 1'b1, H);
        t = 0;
        do begin
            @(negedge clock);
            io_in_valid = 1'b0;
            t++;
        end while (!(io_out_valid && io_out_index == 200) && t < 2000);
        check("reach_idx200", io_out_index, 200);
        #1 reset = 1'b0;
        #1 check("valid_async_drop", io_out_valid, 0);
        exp_q.delete();
        repeat (3) @(negedge clock);
        check_reset_outputs("rst_drain");
        reset = 1'b1;
        idle(5);
        drive_frame(7000, 0, 1'b1, H);
        idle(1);
        wait_drain("post_rst_drain", 2000);
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
